uart_rx_cfg: RTL

//  Configurable UART receiver: async serial line in, parallel word out over a valid/ready handshake.

---
 rtl/uart_rx_cfg.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, 1-2 stop bits) with valid/ready output.
// Parity bit support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 4,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY      = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_rdy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF    = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] LAST    = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LASTIDX = IW'(DATA_BITS - 1);
  localparam logic          LASTSTP = 1'(STOP_BITS - 1);

  generate
    if (CLK_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_badCfg
      $error("uart_rx_cfg: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 r_state;
  logic                   r_rxMeta;
  logic                   r_rxSync;
  logic [CW-1:0]          r_clkCnt;
  logic [IW-1:0]          r_idx;
  logic                   r_stopIdx;
  logic                   r_stopBad;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frameErr;
  logic                   r_overrun;

  logic w_sample;
  logic w_bitEnd;
  logic w_stopLast;
  logic w_frameBad;
  logic w_parBad;

  assign w_sample   = (r_clkCnt == HALF);
  assign w_bitEnd   = (r_clkCnt == LAST);
  assign w_stopLast = (r_stopIdx == LASTSTP);
  assign w_frameBad = r_stopBad | ~r_rxSync;

`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 1);
  logic r_parBad;
  logic r_parityErr;
  assign w_parBad     = r_parBad;
  assign o_parity_err = r_parityErr;
`else
  assign w_parBad     = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= i_rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // Receive FSM plus output register; reception never waits for the consumer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_clkCnt   <= '0;
      r_idx      <= '0;
      r_stopIdx  <= 1'b0;
      r_stopBad  <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parBad    <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
      if (r_valid && i_data_rdy) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_clkCnt  <= '0;
          r_idx     <= '0;
          r_stopIdx <= 1'b0;
          r_stopBad <= 1'b0;
`ifdef UART_RX_PARITY_EN
          r_parBad  <= 1'b0;
`endif
          if (!r_rxSync) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_sample && r_rxSync) begin
            r_state  <= S_IDLE;
            r_clkCnt <= '0;
          end else if (w_bitEnd) begin
            r_state  <= S_DATA;
            r_clkCnt <= '0;
          end else begin
            r_clkCnt <= r_clkCnt + CW'(1);
          end
        end

        S_DATA: begin
          if (w_sample) begin
            r_shift[r_idx] <= r_rxSync;
          end
          if (w_bitEnd) begin
            r_clkCnt <= '0;
            if (r_idx == LASTIDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= HAS_PAR ? S_PARITY : S_STOP;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_clkCnt <= r_clkCnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_sample) begin
            r_parBad <= ODD_PAR ? ~(^r_shift ^ r_rxSync) : (^r_shift ^ r_rxSync);
          end
          if (w_bitEnd) begin
            r_clkCnt <= '0;
            r_state  <= S_STOP;
          end else begin
            r_clkCnt <= r_clkCnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          // The last stop bit finishes at its sample point so a following start bit is never missed.
          if (w_sample && w_stopLast) begin
            r_state  <= S_IDLE;
            r_clkCnt <= '0;
            if (w_frameBad || w_parBad) begin
              r_frameErr <= w_frameBad;
`ifdef UART_RX_PARITY_EN
              r_parityErr <= w_parBad;
`endif
            end else if (!r_valid || i_data_rdy) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            if (w_sample) begin
              r_stopBad <= w_frameBad;
            end
            if (w_bitEnd) begin
              r_clkCnt  <= '0;
              r_stopIdx <= 1'b1;
            end else begin
              r_clkCnt <= r_clkCnt + CW'(1);
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_clkCnt <= '0;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_frameErr;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != S_IDLE);

endmodule
